// File: rtl/cross_product_sequencer_pkg.sv
// cross_product_sequencer_pkg: lane format, saturation bounds and FSM encoding for the sequential cross product.
package cross_product_sequencer_pkg;
   localparam int ELEM_WIDTH = 19;
   localparam int FRAC_BITS = 10;
   localparam int VEC_WIDTH = 3 * ELEM_WIDTH;
   localparam logic [ELEM_WIDTH-1:0] SAT_MAX = 19'h3FFFF;
   localparam logic [ELEM_WIDTH-1:0] SAT_MIN = 19'h40000;
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, SUB = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/cross_product_sequencer_fixed_point_mul_sat.sv
// fixed_point_mul_sat: signed Q8.10 multiply, floor shift by FRAC_BITS, saturate back to one lane.
module fixed_point_mul_sat
   import cross_product_sequencer_pkg::*;
(
   input  logic signed [ELEM_WIDTH-1:0] a,
   input  logic signed [ELEM_WIDTH-1:0] b,
   output logic        [ELEM_WIDTH-1:0] product,
   output logic                         sat
);
   logic signed [2*ELEM_WIDTH-1:0] full;
   logic signed [2*ELEM_WIDTH-1:0] shifted;
   always_comb begin
      full = a * b;
      shifted = full >>> FRAC_BITS;
      // in range only when every bit above the lane sign matches it
      sat = !((&shifted[2*ELEM_WIDTH-1:ELEM_WIDTH-1]) || ~|shifted[2*ELEM_WIDTH-1:ELEM_WIDTH-1]);
      product = sat ? (shifted[2*ELEM_WIDTH-1] ? SAT_MIN : SAT_MAX) : shifted[ELEM_WIDTH-1:0];
   end
endmodule

// File: rtl/cross_product_sequencer.sv
// cross_product_sequencer: V1 x V2 using one shared multiplier over six cycles plus one subtract cycle.
module cross_product_sequencer
   import cross_product_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [VEC_WIDTH-1:0] in_vector_1,
   input  logic [VEC_WIDTH-1:0] in_vector_2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [VEC_WIDTH-1:0] out_vector,
   output logic                 overflow,
   output logic                 busy
);
   state_t state, state_next;
   logic [2:0] step;
   logic [VEC_WIDTH-1:0] v1, v2;
   logic [ELEM_WIDTH-1:0] p [6];
   logic flag;
   logic [ELEM_WIDTH-1:0] mul_a, mul_b, mul_p;
   logic mul_sat;
   logic [ELEM_WIDTH:0] dx, dy, dz;
   logic [ELEM_WIDTH-1:0] x1, y1, z1, x2, y2, z2;

   // returns {sat, value} of a - b clamped to one lane
   function automatic logic [ELEM_WIDTH:0] sub_sat(input logic [ELEM_WIDTH-1:0] a, input logic [ELEM_WIDTH-1:0] b);
      logic [ELEM_WIDTH:0] d;
      logic s;
      d = {a[ELEM_WIDTH-1], a} - {b[ELEM_WIDTH-1], b};
      s = d[ELEM_WIDTH] != d[ELEM_WIDTH-1];
      return {s, s ? (d[ELEM_WIDTH] ? SAT_MIN : SAT_MAX) : d[ELEM_WIDTH-1:0]};
   endfunction

   assign {x1, y1, z1} = v1;
   assign {x2, y2, z2} = v2;
   assign in_ready = state == IDLE;
   assign busy = state != IDLE;
   assign dx = sub_sat(p[0], p[1]);
   assign dy = sub_sat(p[2], p[3]);
   assign dz = sub_sat(p[4], p[5]);

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (step)
         3'd0: begin mul_a = y1; mul_b = z2; end
         3'd1: begin mul_a = z1; mul_b = y2; end
         3'd2: begin mul_a = z1; mul_b = x2; end
         3'd3: begin mul_a = x1; mul_b = z2; end
         3'd4: begin mul_a = x1; mul_b = y2; end
         3'd5: begin mul_a = y1; mul_b = x2; end
         default: begin mul_a = '0; mul_b = '0; end
      endcase
   end

   fixed_point_mul_sat u_mul (
      .a       (mul_a),
      .b       (mul_b),
      .product (mul_p),
      .sat     (mul_sat)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = in_valid ? MUL : IDLE;
         MUL:  state_next = (step == 3'd5) ? SUB : MUL;
         SUB:  state_next = DONE;
         DONE: state_next = out_ready ? IDLE : DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step <= '0;
         v1 <= '0;
         v2 <= '0;
         flag <= 1'b0;
         for (int i = 0; i < 6; i++) p[i] <= '0;
         out_vector <= '0;
         overflow <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               v1 <= in_vector_1;
               v2 <= in_vector_2;
               flag <= 1'b0;
               step <= '0;
            end
            MUL: begin
               p[step] <= mul_p;
               flag <= flag | mul_sat;
               step <= step + 3'd1;
            end
            SUB: begin
               out_vector <= {dx[ELEM_WIDTH-1:0], dy[ELEM_WIDTH-1:0], dz[ELEM_WIDTH-1:0]};
               overflow <= flag | dx[ELEM_WIDTH] | dy[ELEM_WIDTH] | dz[ELEM_WIDTH];
               out_valid <= 1'b1;
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cross_product_sequencer.sv
// tb_cross_product_sequencer: directed vectors with a scoreboard queue checked by an output monitor.
module tb_cross_product_sequencer;
   logic clk = 0;
   logic rst_n = 0;
   logic in_valid = 0;
   logic in_ready;
   logic [56:0] in_vector_1 = '0;
   logic [56:0] in_vector_2 = '0;
   logic out_valid;
   logic out_ready = 1;
   logic [56:0] out_vector;
   logic overflow;
   logic busy;
   int passed = 0;
   int total = 0;
   logic [57:0] sb [$];

   cross_product_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vector_1 (in_vector_1),
      .in_vector_2 (in_vector_2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_vector  (out_vector),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [56:0] vec(input int x, input int y, input int z);
      return {19'(x), 19'(y), 19'(z)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_output: got %h expected none", out_vector);
         end else begin
            logic [57:0] e;
            e = sb.pop_front();
            check("out_vector", 64'(out_vector), 64'(e[57:1]));
            check("overflow", 64'(overflow), 64'(e[0]));
         end
      end
   end

   task automatic accept(input logic [56:0] a, input logic [56:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("in_ready_before_accept", 64'(in_ready), 64'(1));
      in_valid = 1;
      in_vector_1 = a;
      in_vector_2 = b;
      @(posedge clk);
      #1;
      in_valid = 0;
      in_vector_1 = ~a;
      in_vector_2 = ~b;
      check("busy_after_accept", 64'(busy), 64'(1));
   endtask

   task automatic run_op(input logic [56:0] a, input logic [56:0] b, input logic [56:0] ev, input logic eo);
      sb.push_back({ev, eo});
      accept(a, b);
      repeat (6) @(posedge clk);
      #1;
      check("latency_early", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      check("latency_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      check("in_ready_after_handshake", 64'(in_ready), 64'(1));
      check("vector_held_after_handshake", 64'(out_vector), 64'(ev));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [56:0] mixed_exp;
      mixed_exp = vec(-3072, 6144, -3072);
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_out_vector", 64'(out_vector), 64'(0));
      check("reset_overflow", 64'(overflow), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      rst_n = 1;
      @(posedge clk);
      #1;

      run_op(vec(1024, 0, 0), vec(0, 1024, 0), vec(0, 0, 1024), 0);
      run_op(vec(1024, 2048, 3072), vec(4096, 5120, 6144), mixed_exp, 0);
      run_op(vec(-1, 0, 0), vec(0, 512, 0), vec(0, 0, -1), 0);
      run_op(vec(204800, 0, 0), vec(0, 204800, 0), vec(0, 0, 262143), 1);
      run_op(vec(204800, -204800, 0), vec(204800, 204800, 0), vec(0, 0, 262143), 1);
      run_op(vec(1024, 0, 0), vec(0, 1024, 0), vec(0, 0, 1024), 0);

      out_ready = 0;
      sb.push_back({mixed_exp, 1'b0});
      accept(vec(1024, 2048, 3072), vec(4096, 5120, 6144));
      repeat (7) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1;
         in_vector_1 = vec(204800, 204800, 204800);
         in_vector_2 = vec(-204800, 1024, 204800);
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_out_vector", 64'(out_vector), 64'(mixed_exp));
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk);
      #1;
      check("bp_in_ready_after", 64'(in_ready), 64'(1));
      check("bp_out_valid_after", 64'(out_valid), 64'(0));

      accept(vec(1024, 2048, 3072), vec(4096, 5120, 6144));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      check("midreset_out_valid", 64'(out_valid), 64'(0));
      check("midreset_out_vector", 64'(out_vector), 64'(0));
      check("midreset_overflow", 64'(overflow), 64'(0));
      check("midreset_busy", 64'(busy), 64'(0));
      check("midreset_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1;
      repeat (8) @(posedge clk);
      #1;
      check("midreset_no_output", 64'(out_valid), 64'(0));
      run_op(vec(1024, 0, 0), vec(0, 1024, 0), vec(0, 0, 1024), 0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
